// File: rtl/icd_pkg.sv
// Shared definitions for the task parser: header layout, status codes and
// the parser state encoding.
package icd_pkg;

  // Header word positions inside a task message.
  localparam int LEN_IDX      = 0;
  localparam int TASK_ID_IDX  = 1;
  localparam int STATUS_IDX   = 2;
  localparam int HEADER_WORDS = 3;

  // Status code returned in the response header.
  typedef enum logic [1:0] {
    TASK_VALID   = 2'd0,
    TASK_INVALID = 2'd1,
    TASK_TIMEOUT = 2'd2
  } status_e;

  // Parser control state.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNK      = 3'd1,
    VALIDATE = 3'd2,
    SRC_CMD  = 3'd3,
    SRC_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/task_msg_buf.sv
// Message buffer: DEPTH x DATA_W register array with one write port that
// appends at a saturating word count, one indexed read port and direct taps
// on the length and task_id header words. Writes past the end are dropped
// and raise the overflow flag.
module task_msg_buf
  import icd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,       // empty the buffer (count/overflow)
  input  logic                       wr_first,  // restart: store at word 0
  input  logic                       wr_en,     // append at current count
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W-1:0]          hdr_len,
  output logic [DATA_W-1:0]          hdr_id,
  output logic [$clog2(DEPTH+1)-1:0] word_cnt,
  output logic                       overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // Next buffer contents, count and overflow flag.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    mem_d = mem_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (wr_first) begin
      mem_d[0] = wr_data;
      cnt_d    = CNT_W'(1);
      ovf_d    = 1'b0;
    end else if (wr_en) begin
      if (cnt_q < CNT_W'(DEPTH)) begin
        mem_d[IDX_W'(cnt_q)] = wr_data;
        cnt_d                = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset on purpose so stale header words never leak into a response.
      mem_q <= '{default: '0};
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together at the edge.
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign rd_data  = mem_q[rd_idx];
  assign hdr_len  = mem_q[LEN_IDX];
  assign hdr_id   = mem_q[TASK_ID_IDX];
  assign word_cnt = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/task_parser_mc.sv
// Multi-channel task parser. Captures a framed task into task_msg_buf,
// checks its header, forwards the payload to channel task_id as a framed
// command stream and returns a three-word response header with the status.
// Optional build macro: TASK_PARSER_TIMEOUT_EN adds parameter TIMEOUT_CYC and
// aborts a stalled capture with status TASK_TIMEOUT.
module task_parser_mc
  import icd_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MAX_MSG_WORDS = 16,
  parameter int NUM_CH        = 2
`ifdef TASK_PARSER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC   = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              asi_task_ready,
  input  logic              asi_task_valid,
  input  logic              asi_task_sop,
  input  logic              asi_task_eop,
  input  logic [DATA_W-1:0] asi_task_data,
  input  logic              aso_resp_ready,
  output logic              aso_resp_valid,
  output logic              aso_resp_sop,
  output logic              aso_resp_eop,
  output logic [DATA_W-1:0] aso_resp_data,
  input  logic [NUM_CH-1:0] aso_cmd_ready,
  output logic [NUM_CH-1:0] aso_cmd_valid,
  output logic              aso_cmd_sop,
  output logic              aso_cmd_eop,
  output logic [DATA_W-1:0] aso_cmd_data
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = $clog2(MAX_MSG_WORDS);
  localparam int CNT_W = $clog2(MAX_MSG_WORDS + 1);
  localparam logic [DATA_W-1:0] BPW_V   = DATA_W'(BPW);
  localparam logic [DATA_W-1:0] MIN_LEN = DATA_W'(HEADER_WORDS * BPW);
  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(MAX_MSG_WORDS * BPW);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  status_e           status_q, status_d;

  logic              task_ready_q, task_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_sop_q, resp_sop_d;
  logic              resp_eop_q, resp_eop_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [NUM_CH-1:0] cmd_valid_q, cmd_valid_d;
  logic              cmd_sop_q, cmd_sop_d;
  logic              cmd_eop_q, cmd_eop_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;

  logic              buf_clr, buf_wr_first, buf_wr;
  logic [DATA_W-1:0] buf_rd_data, buf_hdr_len, buf_hdr_id;
  logic [CNT_W-1:0]  word_cnt;
  logic              overflow;

  logic              task_xfer, cmd_xfer, resp_xfer;
  logic [DATA_W-1:0] hdr_len, hdr_id;
  logic              task_invalid, cmd_last;

  task_msg_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_MSG_WORDS)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (buf_clr),
    .wr_first (buf_wr_first),
    .wr_en    (buf_wr),
    .wr_data  (asi_task_data),
    .rd_idx   (rd_idx_d),
    .rd_data  (buf_rd_data),
    .hdr_len  (buf_hdr_len),
    .hdr_id   (buf_hdr_id),
    .word_cnt (word_cnt),
    .overflow (overflow)
  );

  assign task_xfer = asi_task_valid & task_ready_q;
  assign cmd_xfer  = |(cmd_valid_q & aso_cmd_ready);
  assign resp_xfer = resp_valid_q & aso_resp_ready;

  // Header words that were never written in this task read as zero.
  assign hdr_len = (word_cnt >= CNT_W'(1)) ? buf_hdr_len : '0;
  assign hdr_id  = (word_cnt >= CNT_W'(2)) ? buf_hdr_id  : '0;

  assign task_invalid = overflow
                     || (hdr_len != DATA_W'(word_cnt) * BPW_V)
                     || (hdr_len < MIN_LEN) || (hdr_len > MAX_LEN)
                     || (hdr_id >= DATA_W'(NUM_CH));

  assign cmd_last = (CNT_W'(rd_idx_q) == word_cnt - CNT_W'(1));

`ifdef TASK_PARSER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Idle-cycle counter: runs only in SNK, cleared by any transfer or on leaving SNK.
  always_comb begin
    tmo_d = '0;
    if (state_q == SNK && !task_xfer) tmo_d = tmo_q + TMO_W'(1);
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // State, read index and status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_idx_q <= '0;
      status_q <= TASK_VALID;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      status_q <= status_d;
    end
  end

  // Next-state logic plus buffer write/clear control.
  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    status_d     = status_q;
    buf_clr      = 1'b0;
    buf_wr_first = 1'b0;
    buf_wr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (task_xfer && asi_task_sop) begin
          buf_wr_first = 1'b1;
          state_d      = asi_task_eop ? VALIDATE : SNK;
        end
      end
      SNK: begin
        if (task_xfer) begin
          buf_wr_first = asi_task_sop;
          buf_wr       = !asi_task_sop;
          if (asi_task_eop) state_d = VALIDATE;
        end
`ifdef TASK_PARSER_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d  = SRC_RESP;
          rd_idx_d = '0;
          status_d = TASK_TIMEOUT;
        end
`endif
      end
      VALIDATE: begin
        status_d = task_invalid ? TASK_INVALID : TASK_VALID;
        if (!task_invalid && word_cnt > CNT_W'(HEADER_WORDS)) begin
          state_d  = SRC_CMD;
          rd_idx_d = IDX_W'(HEADER_WORDS);
        end else begin
          state_d  = SRC_RESP;
          rd_idx_d = '0;
        end
      end
      SRC_CMD: begin
        if (cmd_xfer) begin
          if (cmd_last) begin
            state_d  = SRC_RESP;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      SRC_RESP: begin
        if (resp_xfer) begin
          if (rd_idx_q == IDX_W'(STATUS_IDX)) begin
            state_d  = IDLE;
            rd_idx_d = '0;
            buf_clr  = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered stream outputs, derived from the state being entered.
  always_comb begin
    task_ready_d = (state_d == IDLE) || (state_d == SNK);
    cmd_valid_d  = '0;
    cmd_sop_d    = 1'b0;
    cmd_eop_d    = 1'b0;
    cmd_data_d   = '0;
    resp_valid_d = 1'b0;
    resp_sop_d   = 1'b0;
    resp_eop_d   = 1'b0;
    resp_data_d  = '0;
    if (state_d == SRC_CMD) begin
      for (int c = 0; c < NUM_CH; c++) cmd_valid_d[c] = (hdr_id == DATA_W'(c));
      cmd_data_d = buf_rd_data;
      cmd_sop_d  = (rd_idx_d == IDX_W'(HEADER_WORDS));
      cmd_eop_d  = (CNT_W'(rd_idx_d) == word_cnt - CNT_W'(1));
    end
    if (state_d == SRC_RESP) begin
      resp_valid_d = 1'b1;
      resp_sop_d   = (rd_idx_d == IDX_W'(LEN_IDX));
      resp_eop_d   = (rd_idx_d == IDX_W'(STATUS_IDX));
      if (rd_idx_d == IDX_W'(LEN_IDX))           resp_data_d = MIN_LEN;
      else if (rd_idx_d == IDX_W'(TASK_ID_IDX))  resp_data_d = hdr_id;
      else                                       resp_data_d = DATA_W'(status_d);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      task_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_sop_q   <= 1'b0;
      resp_eop_q   <= 1'b0;
      resp_data_q  <= '0;
      cmd_valid_q  <= '0;
      cmd_sop_q    <= 1'b0;
      cmd_eop_q    <= 1'b0;
      cmd_data_q   <= '0;
    end else begin
      task_ready_q <= task_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_sop_q   <= resp_sop_d;
      resp_eop_q   <= resp_eop_d;
      resp_data_q  <= resp_data_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_sop_q    <= cmd_sop_d;
      cmd_eop_q    <= cmd_eop_d;
      cmd_data_q   <= cmd_data_d;
    end
  end

  assign asi_task_ready = task_ready_q;
  assign aso_resp_valid = resp_valid_q;
  assign aso_resp_sop   = resp_sop_q;
  assign aso_resp_eop   = resp_eop_q;
  assign aso_resp_data  = resp_data_q;
  assign aso_cmd_valid  = cmd_valid_q;
  assign aso_cmd_sop    = cmd_sop_q;
  assign aso_cmd_eop    = cmd_eop_q;
  assign aso_cmd_data   = cmd_data_q;

endmodule
